rv_decoder: RTL and testbench

- RV32I instruction decoder for the single-issue core.
- Takes the fetched 32-bit instruction and produces the datapath control selects: PC mux, ALU operand muxes, write-back data/register muxes, write enable, ALU op, branch/memory ops, immediate and register indices.
- Outputs are registered: one pipeline stage between fetch and execute.

---
 rtl/decoder_pkg.sv | 71 +++++++
 rtl/rv_decoder_if.sv | 38 +++
 rtl/rv_decoder_imm_gen.sv | 23 ++
 rtl/rv_decoder.sv | 153 +++++++++++++++
 tb/tb_rv_decoder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared types for the RV32I decoder: mux selects, ALU ops, immediate formats, opcodes.
// Pure declarations, no timing; no flow control.
package decoder_pkg;

    typedef enum logic [1:0] {PC_NEXT, PC_BRANCH, PC_JAL, PC_JALR} pc_mux_t;
    typedef enum logic [1:0] {WB_ALU, WB_DM, WB_CSR, WB_PC4} wb_data_mux_t;
    typedef enum logic       {WB_REG_RD, WB_REG_RA} wb_reg_mux_t;
    typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} alu_a_mux_t;
    typedef enum logic       {B_RS2, B_IMM} alu_b_mux_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;
    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef struct packed {
        pc_mux_t      pc_sel;
        wb_data_mux_t wb_data_sel;
        wb_reg_mux_t  wb_reg_sel;
        logic         wb_en;
        alu_a_mux_t   alu_a_sel;
        alu_b_mux_t   alu_b_sel;
        alu_op_t      alu_op;
        logic [2:0]   branch_op;
        logic         mem_read;
        logic         mem_write;
        logic [2:0]   mem_width;
        logic [31:0]  imm;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic         illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        pc_sel: PC_NEXT, wb_data_sel: WB_ALU, wb_reg_sel: WB_REG_RD, wb_en: 1'b0,
        alu_a_sel: A_RS1, alu_b_sel: B_RS2, alu_op: ALU_ADD, branch_op: 3'b000,
        mem_read: 1'b0, mem_write: 1'b0, mem_width: 3'b000, imm: 32'h0,
        rs1: 5'd0, rs2: 5'd0, rd: 5'd0, illegal: 1'b0
    };

    // alt selects SUB/SRA; callers must only raise it where the encoding means that
    function automatic alu_op_t alu_op_from(input logic alt, input logic [2:0] funct3);
        alu_op_t op;
        op = ALU_ADD;
        case (funct3)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_decoder_if.sv
// Instruction in / registered control selects out between fetch and execute.
// No handshake: the decoder consumes instr every cycle.
interface rv_decoder_if;
    import decoder_pkg::*;

    logic [31:0]  instr;
    pc_mux_t      pc_mux_sel;
    wb_data_mux_t wb_data_mux_sel;
    wb_reg_mux_t  wb_reg_mux_sel;
    logic         wb_enable;
    alu_a_mux_t   alu_a_mux_sel;
    alu_b_mux_t   alu_b_mux_sel;
    alu_op_t      alu_op;
    logic [2:0]   branch_op;
    logic         mem_read;
    logic         mem_write;
    logic [2:0]   mem_width;
    logic [31:0]  imm;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         illegal;

    modport master (
        output instr,
        input  pc_mux_sel, wb_data_mux_sel, wb_reg_mux_sel, wb_enable,
        input  alu_a_mux_sel, alu_b_mux_sel, alu_op, branch_op,
        input  mem_read, mem_write, mem_width, imm, rs1, rs2, rd, illegal
    );

    modport slave (
        input  instr,
        output pc_mux_sel, wb_data_mux_sel, wb_reg_mux_sel, wb_enable,
        output alu_a_mux_sel, alu_b_mux_sel, alu_op, branch_op,
        output mem_read, mem_write, mem_width, imm, rs1, rs2, rd, illegal
    );

endinterface

// File: rtl/rv_decoder_imm_gen.sv
// Sign-extended immediate from instruction bits for the selected format.
// Combinational, zero latency; no flow control.
module rv_decoder_imm_gen
    import decoder_pkg::*;
(
    input  logic [31:7] bits,
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{bits[31]}}, bits[31:20]};
            IMM_S:   imm = {{20{bits[31]}}, bits[31:25], bits[11:7]};
            IMM_B:   imm = {{19{bits[31]}}, bits[31], bits[7], bits[30:25], bits[11:8], 1'b0};
            IMM_U:   imm = {bits[31:12], 12'h000};
            IMM_J:   imm = {{11{bits[31]}}, bits[31], bits[19:12], bits[20], bits[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv_decoder.sv
// RV32I decoder: opcode case into datapath selects, registered once (1-cycle latency).
// No backpressure: a new instruction is accepted on every clk edge; reset forces a NOP.
module rv_decoder
    import decoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    rv_decoder_if.slave dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    imm_fmt_t    fmt;
    logic [31:0] imm;
    logic        bad;
    ctrl_t       d;
    ctrl_t       q;

    assign opcode = dec.instr[6:0];
    assign funct3 = dec.instr[14:12];
    assign funct7 = dec.instr[31:25];

    always_comb begin
        fmt = IMM_NONE;
        case (opcode)
            OPC_LUI, OPC_AUIPC:                      fmt = IMM_U;
            OPC_JAL:                                 fmt = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM: fmt = IMM_I;
            OPC_BRANCH:                              fmt = IMM_B;
            OPC_STORE:                               fmt = IMM_S;
            default:                                 fmt = IMM_NONE;
        endcase
    end

    rv_decoder_imm_gen imm_gen (
        .bits (dec.instr[31:7]),
        .fmt  (fmt),
        .imm  (imm)
    );

    always_comb begin
        d     = CTRL_NOP;
        bad   = 1'b0;
        d.rs1 = dec.instr[19:15];
        d.rs2 = dec.instr[24:20];
        d.rd  = dec.instr[11:7];
        d.imm = imm;
        case (opcode)
            OPC_LUI: begin
                d.alu_a_sel = A_ZERO;
                d.alu_b_sel = B_IMM;
                d.wb_en     = 1'b1;
            end
            OPC_AUIPC: begin
                d.alu_a_sel = A_PC;
                d.alu_b_sel = B_IMM;
                d.wb_en     = 1'b1;
            end
            OPC_JAL: begin
                d.pc_sel      = PC_JAL;
                d.wb_data_sel = WB_PC4;
                d.alu_a_sel   = A_PC;
                d.alu_b_sel   = B_IMM;
                d.wb_en       = 1'b1;
            end
            OPC_JALR: begin
                d.pc_sel      = PC_JALR;
                d.wb_data_sel = WB_PC4;
                d.alu_b_sel   = B_IMM;
                d.wb_en       = 1'b1;
                bad           = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                d.pc_sel    = PC_BRANCH;
                d.branch_op = funct3;
                d.alu_op    = ALU_SUB;
                bad         = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                d.mem_read    = 1'b1;
                d.mem_width   = funct3;
                d.wb_data_sel = WB_DM;
                d.alu_b_sel   = B_IMM;
                d.wb_en       = 1'b1;
                bad           = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                d.mem_write = 1'b1;
                d.mem_width = funct3;
                d.alu_b_sel = B_IMM;
                bad         = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                d.alu_b_sel = B_IMM;
                d.alu_op    = alu_op_from(dec.instr[30] && (funct3 == 3'b101), funct3);
                d.wb_en     = 1'b1;
                // shift-immediate encodings reuse funct7 as a sub-opcode
                if (funct3 == 3'b001)
                    bad = (funct7 != 7'b0000000);
                else if (funct3 == 3'b101)
                    bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
            OPC_OP: begin
                d.alu_op = alu_op_from(dec.instr[30], funct3);
                d.wb_en  = 1'b1;
                bad      = (funct7 != 7'b0000000) && !((funct7 == 7'b0100000) &&
                           ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b100) begin
                    bad = 1'b1;
                end else if (funct3 != 3'b000) begin
                    d.wb_data_sel = WB_CSR;
                    d.wb_en       = 1'b1;
                end
            end
            OPC_FENCE: d.imm = '0;
            default:   bad = 1'b1;
        endcase
        if (d.rd == 5'd0)
            d.wb_en = 1'b0;
        if (bad) begin
            d         = CTRL_NOP;
            d.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            q <= CTRL_NOP;
        else
            q <= d;
    end

    assign dec.pc_mux_sel      = q.pc_sel;
    assign dec.wb_data_mux_sel = q.wb_data_sel;
    assign dec.wb_reg_mux_sel  = q.wb_reg_sel;
    assign dec.wb_enable       = q.wb_en;
    assign dec.alu_a_mux_sel   = q.alu_a_sel;
    assign dec.alu_b_mux_sel   = q.alu_b_sel;
    assign dec.alu_op          = q.alu_op;
    assign dec.branch_op       = q.branch_op;
    assign dec.mem_read        = q.mem_read;
    assign dec.mem_write       = q.mem_write;
    assign dec.mem_width       = q.mem_width;
    assign dec.imm             = q.imm;
    assign dec.rs1             = q.rs1;
    assign dec.rs2             = q.rs2;
    assign dec.rd              = q.rd;
    assign dec.illegal         = q.illegal;

endmodule

// File: tb/tb_rv_decoder.sv
// Directed-vector bench for rv_decoder: hand-decoded RV32I words checked one cycle after drive.
module tb_rv_decoder;
    import decoder_pkg::*;

    logic clk;
    logic reset;
    int   errs;
    int   checks;

    rv_decoder_if dec ();

    rv_decoder dut (
        .clk   (clk),
        .reset (reset),
        .dec   (dec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // drive away from the edge, let one rising edge capture it, sample 1ns later
    task automatic step(input logic r, input logic [31:0] i);
        @(negedge clk);
        reset     = r;
        dec.instr = i;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errs      = 0;
        checks    = 0;
        reset     = 1'b1;
        dec.instr = 32'h0;

        // reset beats a legal addi
        step(1'b1, 32'h00500093);
        chk("rst_wb",      32'(dec.wb_enable),     32'd0);
        chk("rst_illegal", 32'(dec.illegal),       32'd0);
        chk("rst_pc",      32'(dec.pc_mux_sel),    32'(PC_NEXT));
        chk("rst_imm",     dec.imm,                32'h0);
        chk("rst_rd",      32'(dec.rd),            32'd0);
        chk("rst_bsel",    32'(dec.alu_b_mux_sel), 32'(B_RS2));

        step(1'b0, 32'h00000000);
        chk("zero_illegal", 32'(dec.illegal),   32'd1);
        chk("zero_wb",      32'(dec.wb_enable), 32'd0);
        chk("zero_memw",    32'(dec.mem_write), 32'd0);

        // addi x1,x0,5
        step(1'b0, 32'h00500093);
        chk("addi_rd",   32'(dec.rd),              32'd1);
        chk("addi_rs1",  32'(dec.rs1),             32'd0);
        chk("addi_imm",  dec.imm,                  32'd5);
        chk("addi_asel", 32'(dec.alu_a_mux_sel),   32'(A_RS1));
        chk("addi_bsel", 32'(dec.alu_b_mux_sel),   32'(B_IMM));
        chk("addi_op",   32'(dec.alu_op),          32'(ALU_ADD));
        chk("addi_wbd",  32'(dec.wb_data_mux_sel), 32'(WB_ALU));
        chk("addi_wb",   32'(dec.wb_enable),       32'd1);
        chk("addi_pc",   32'(dec.pc_mux_sel),      32'(PC_NEXT));
        chk("addi_ill",  32'(dec.illegal),         32'd0);

        // add x3,x1,x2 then sub x3,x1,x2
        step(1'b0, 32'h002081B3);
        chk("add_bsel", 32'(dec.alu_b_mux_sel), 32'(B_RS2));
        chk("add_rd",   32'(dec.rd),            32'd3);
        chk("add_rs2",  32'(dec.rs2),           32'd2);
        chk("add_op",   32'(dec.alu_op),        32'(ALU_ADD));
        chk("add_wb",   32'(dec.wb_enable),     32'd1);
        chk("add_imm",  dec.imm,                32'h0);
        step(1'b0, 32'h402081B3);
        chk("sub_op",   32'(dec.alu_op),        32'(ALU_SUB));
        chk("sub_wb",   32'(dec.wb_enable),     32'd1);

        // jal x1,8 then beq x1,x2,-4
        step(1'b0, 32'h008000EF);
        chk("jal_pc",  32'(dec.pc_mux_sel),      32'(PC_JAL));
        chk("jal_wbd", 32'(dec.wb_data_mux_sel), 32'(WB_PC4));
        chk("jal_imm", dec.imm,                  32'd8);
        chk("jal_wb",  32'(dec.wb_enable),       32'd1);
        chk("jal_asel", 32'(dec.alu_a_mux_sel),  32'(A_PC));
        step(1'b0, 32'hFE208EE3);
        chk("beq_pc",  32'(dec.pc_mux_sel), 32'(PC_BRANCH));
        chk("beq_bop", 32'(dec.branch_op),  32'd0);
        chk("beq_imm", dec.imm,             32'hFFFFFFFC);
        chk("beq_wb",  32'(dec.wb_enable),  32'd0);
        chk("beq_op",  32'(dec.alu_op),     32'(ALU_SUB));
        chk("beq_rs1", 32'(dec.rs1),        32'd1);

        // lui x5,0x12345 then addi x0,x0,1
        step(1'b0, 32'h123452B7);
        chk("lui_asel", 32'(dec.alu_a_mux_sel), 32'(A_ZERO));
        chk("lui_bsel", 32'(dec.alu_b_mux_sel), 32'(B_IMM));
        chk("lui_imm",  dec.imm,                32'h12345000);
        chk("lui_rd",   32'(dec.rd),            32'd5);
        step(1'b0, 32'h00100013);
        chk("x0_wb",  32'(dec.wb_enable), 32'd0);
        chk("x0_ill", 32'(dec.illegal),   32'd0);
        chk("x0_imm", dec.imm,            32'd1);

        // lw x5,8(x2)
        step(1'b0, 32'h00812283);
        chk("lw_rd",    32'(dec.mem_read),        32'd1);
        chk("lw_width", 32'(dec.mem_width),       32'd2);
        chk("lw_wbd",   32'(dec.wb_data_mux_sel), 32'(WB_DM));
        chk("lw_imm",   dec.imm,                  32'd8);
        // sw x5,12(x2)
        step(1'b0, 32'h00512623);
        chk("sw_memw", 32'(dec.mem_write), 32'd1);
        chk("sw_wb",   32'(dec.wb_enable), 32'd0);
        chk("sw_imm",  dec.imm,            32'd12);
        chk("sw_rs2",  32'(dec.rs2),       32'd5);
        // store funct3=011 and branch funct3=010 are illegal
        step(1'b0, 32'h00513623);
        chk("sd_ill",  32'(dec.illegal),   32'd1);
        chk("sd_memw", 32'(dec.mem_write), 32'd0);
        step(1'b0, 32'hFE20AEE3);
        chk("b010_ill", 32'(dec.illegal),    32'd1);
        chk("b010_pc",  32'(dec.pc_mux_sel), 32'(PC_NEXT));
        // srai x1,x1,3
        step(1'b0, 32'h4030D093);
        chk("srai_op",  32'(dec.alu_op),  32'(ALU_SRA));
        chk("srai_ill", 32'(dec.illegal), 32'd0);
        // OP with funct7=0000001 is outside RV32I
        step(1'b0, 32'h022081B3);
        chk("mul_ill", 32'(dec.illegal),   32'd1);
        chk("mul_wb",  32'(dec.wb_enable), 32'd0);
        // csrrw x1,0x300,x2
        step(1'b0, 32'h300110F3);
        chk("csr_wbd", 32'(dec.wb_data_mux_sel), 32'(WB_CSR));
        chk("csr_wb",  32'(dec.wb_enable),       32'd1);
        // ecall
        step(1'b0, 32'h00000073);
        chk("ecall_wb",  32'(dec.wb_enable),  32'd0);
        chk("ecall_ill", 32'(dec.illegal),    32'd0);
        chk("ecall_pc",  32'(dec.pc_mux_sel), 32'(PC_NEXT));
        // jalr x1,0(x5)
        step(1'b0, 32'h000280E7);
        chk("jalr_pc",   32'(dec.pc_mux_sel),      32'(PC_JALR));
        chk("jalr_wbd",  32'(dec.wb_data_mux_sel), 32'(WB_PC4));
        chk("jalr_asel", 32'(dec.alu_a_mux_sel),   32'(A_RS1));
        // auipc x2,1
        step(1'b0, 32'h00001117);
        chk("auipc_asel", 32'(dec.alu_a_mux_sel), 32'(A_PC));
        chk("auipc_imm",  dec.imm,                32'h00001000);
        chk("auipc_rd",   32'(dec.rd),            32'd2);

        // reset again mid-stream with a jal pending
        step(1'b1, 32'h008000EF);
        chk("rst2_pc",  32'(dec.pc_mux_sel),      32'(PC_NEXT));
        chk("rst2_wbd", 32'(dec.wb_data_mux_sel), 32'(WB_ALU));
        chk("rst2_wb",  32'(dec.wb_enable),       32'd0);
        chk("rst2_imm", dec.imm,                  32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
